// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//   mode_t     : per-cycle operation select (HOLD/SHL/SHR/LOAD)
//   cnt_width  : width of the shift counter able to hold 0..w
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } mode_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_cell.sv
// One bit of the universal shift register: 4:1 next-state mux feeding an
// async-low-reset flop with clock enable.
// Ports:
//   CLK, n_Reset : clock, asynchronous active-low reset
//   EN           : clock enable (0 = hold regardless of MODE)
//   MODE         : operation select
//   i_left       : bit to the left (next higher bit, or SI_R at the MSB), used by SHR
//   i_right      : bit to the right (next lower bit, or SI_L at the LSB), used by SHL
//   i_d          : parallel load bit
//   o_q          : stored bit
module shift_cell
  import shift_reg_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  CLK,
  input  logic  n_Reset,
  input  logic  EN,
  input  mode_t MODE,
  input  logic  i_left,
  input  logic  i_right,
  input  logic  i_d,
  output logic  o_q
);

  logic r_q;

  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      r_q <= RESET_BIT;
    end else if (EN) begin
      case (MODE)
        HOLD: r_q <= r_q;
        SHL:  r_q <= i_right;
        SHR:  r_q <= i_left;
        LOAD: r_q <= i_d;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold, parallel load, shift left, shift right.
// Tracks a saturating count of shifts since the last LOAD and flags DONE when
// a full word has been shifted.
// Ports:
//   CLK, n_Reset : clock, asynchronous active-low reset
//   EN           : clock enable; 0 = full hold
//   MODE         : HOLD/SHL/SHR/LOAD
//   D            : parallel load data
//   SI_L / SI_R  : serial input for SHL (into Q[0]) / SHR (into Q[WIDTH-1])
//   Q            : register contents
//   SO_L / SO_R  : Q[WIDTH-1] / Q[0]
//   CNT          : shifts since last LOAD, saturating at WIDTH
//   DONE         : CNT == WIDTH
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                            CLK,
  input  logic                            n_Reset,
  input  logic                            EN,
  input  mode_t                           MODE,
  input  logic [WIDTH-1:0]                D,
  input  logic                            SI_L,
  input  logic                            SI_R,
  output logic [WIDTH-1:0]                Q,
  output logic                            SO_L,
  output logic                            SO_R,
  output logic [cnt_width(WIDTH)-1:0]     CNT,
  output logic                            DONE
);

  localparam int             CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [CW-1:0]    r_cnt;

  // Edge bits take the serial inputs in place of a missing neighbour; for
  // WIDTH==1 the single cell sees SI_R on the left and SI_L on the right.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_left;
    logic w_right;

    if (i == WIDTH - 1) begin : g_msb
      assign w_left = SI_R;
    end else begin : g_mid_l
      assign w_left = w_q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign w_right = SI_L;
    end else begin : g_mid_r
      assign w_right = w_q[i-1];
    end

    shift_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .CLK     (CLK),
      .n_Reset (n_Reset),
      .EN      (EN),
      .MODE    (MODE),
      .i_left  (w_left),
      .i_right (w_right),
      .i_d     (D[i]),
      .o_q     (w_q[i])
    );
  end

  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      r_cnt <= '0;
    end else if (EN) begin
      case (MODE)
        SHL, SHR: if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
        LOAD:     r_cnt <= '0;
        default:  r_cnt <= r_cnt;
      endcase
    end
  end

  assign Q    = w_q;
  assign SO_L = w_q[WIDTH-1];
  assign SO_R = w_q[0];
  assign CNT  = r_cnt;
  assign DONE = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  logic       CLK = 1'b0;
  logic       n_Reset = 1'b0;
  logic       EN = 1'b0;
  mode_t      MODE = HOLD;
  logic [7:0] D = '0;
  logic       D1 = 1'b0;
  logic       SI_L = 1'b0;
  logic       SI_R = 1'b0;

  logic [7:0] q8, q81;
  logic       sol8, sor8, sol81, sor81, done8, done81;
  logic [3:0] cnt8, cnt81;
  logic       q1, sol1, sor1, done1;
  logic [0:0] cnt1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
    .CLK(CLK), .n_Reset(n_Reset), .EN(EN), .MODE(MODE), .D(D),
    .SI_L(SI_L), .SI_R(SI_R), .Q(q8), .SO_L(sol8), .SO_R(sor8),
    .CNT(cnt8), .DONE(done8));

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h81)) dut81 (
    .CLK(CLK), .n_Reset(n_Reset), .EN(EN), .MODE(MODE), .D(D),
    .SI_L(SI_L), .SI_R(SI_R), .Q(q81), .SO_L(sol81), .SO_R(sor81),
    .CNT(cnt81), .DONE(done81));

  shift_reg_univ #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .CLK(CLK), .n_Reset(n_Reset), .EN(EN), .MODE(MODE), .D(D1),
    .SI_L(SI_L), .SI_R(SI_R), .Q(q1), .SO_L(sol1), .SO_R(sor1),
    .CNT(cnt1), .DONE(done1));

  // Drive on falling edge, sample 1 unit after the rising edge.
  task automatic op(input mode_t m, input logic en, input logic [7:0] d,
                    input logic sil, input logic sir);
    @(negedge CLK);
    MODE = m; EN = en; D = d; SI_L = sil; SI_R = sir;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    n_Reset = 1'b1;
    op(LOAD, 1'b1, 8'hA5, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hA5) begin failures++; $display("FAIL rst_preload q=%h exp=%h", q8, 8'hA5); end
    @(negedge CLK); #2;
    n_Reset = 1'b0;
    #1;
    checks++; if (q8 !== 8'h00) begin failures++; $display("FAIL rst_q q=%h exp=%h", q8, 8'h00); end
    checks++; if (cnt8 !== 4'd0) begin failures++; $display("FAIL rst_cnt cnt=%0d exp=0", cnt8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL rst_done done=%b exp=0", done8); end
    checks++; if (q81 !== 8'h81) begin failures++; $display("FAIL rst_val81 q=%h exp=%h", q81, 8'h81); end
    checks++; if (q1 !== 1'b0 || cnt1 !== 1'b0) begin failures++; $display("FAIL rst_w1 q=%b cnt=%b exp=0/0", q1, cnt1); end
    @(negedge CLK);
    n_Reset = 1'b1;
  endtask

  task automatic test_load_hold();
    op(LOAD, 1'b1, 8'h3C, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h3C || cnt8 !== 4'd0) begin failures++; $display("FAIL load q=%h cnt=%0d exp=3c/0", q8, cnt8); end
    for (int k = 0; k < 3; k++) begin
      op(SHL, 1'b0, 8'hFF, 1'b1, 1'b1);
      checks++; if (q8 !== 8'h3C || cnt8 !== 4'd0) begin failures++; $display("FAIL en_hold%0d q=%h cnt=%0d exp=3c/0", k, q8, cnt8); end
    end
    op(HOLD, 1'b1, 8'hFF, 1'b1, 1'b1);
    checks++; if (q8 !== 8'h3C || cnt8 !== 4'd0) begin failures++; $display("FAIL mode_hold q=%h cnt=%0d exp=3c/0", q8, cnt8); end
  endtask

  task automatic test_piso();
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0100;
    op(LOAD, 1'b1, 8'hB4, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++; if (sol8 !== exp_bits[7-k]) begin failures++; $display("FAIL piso_so%0d so_l=%b exp=%b", k, sol8, exp_bits[7-k]); end
      if (k == 7) begin
        checks++; if (cnt8 !== 4'd7 || done8 !== 1'b0) begin failures++; $display("FAIL piso_cnt7 cnt=%0d done=%b exp=7/0", cnt8, done8); end
      end
      op(SHL, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    checks++; if (q8 !== 8'h00 || cnt8 !== 4'd8 || done8 !== 1'b1) begin failures++; $display("FAIL piso_end q=%h cnt=%0d done=%b exp=00/8/1", q8, cnt8, done8); end
  endtask

  task automatic test_sipo_saturation();
    logic [7:0] bits;
    bits = 8'b1100_1010;  // sent MSB of this vector first
    op(LOAD, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) op(SHR, 1'b1, 8'h00, 1'b0, bits[7-k]);
    checks++; if (q8 !== 8'h53 || done8 !== 1'b1 || sor8 !== 1'b1) begin failures++; $display("FAIL sipo q=%h done=%b so_r=%b exp=53/1/1", q8, done8, sor8); end
    op(SHR, 1'b1, 8'h00, 1'b0, 1'b1);
    checks++; if (q8 !== 8'hA9 || cnt8 !== 4'd8 || done8 !== 1'b1) begin failures++; $display("FAIL sat q=%h cnt=%0d done=%b exp=a9/8/1", q8, cnt8, done8); end
  endtask

  task automatic test_reset_mid();
    op(LOAD, 1'b1, 8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) op(SHL, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hF0 || cnt8 !== 4'd4) begin failures++; $display("FAIL mid_pre q=%h cnt=%0d exp=f0/4", q8, cnt8); end
    @(negedge CLK); #2;
    n_Reset = 1'b0;
    #1;
    checks++; if (q8 !== 8'h00 || cnt8 !== 4'd0) begin failures++; $display("FAIL mid_rst q=%h cnt=%0d exp=00/0", q8, cnt8); end
    @(negedge CLK);
    n_Reset = 1'b1; MODE = SHL; EN = 1'b1; SI_L = 1'b1;
    @(posedge CLK); #1;
    checks++; if (q8 !== 8'h01 || cnt8 !== 4'd1) begin failures++; $display("FAIL mid_release q=%h cnt=%0d exp=01/1", q8, cnt8); end
    checks++; if (q81 !== 8'h03) begin failures++; $display("FAIL mid_release81 q=%h exp=03", q81); end
  endtask

  task automatic test_width1();
    D1 = 1'b0;
    op(LOAD, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++; if (q1 !== 1'b0 || cnt1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL w1_load q=%b cnt=%b done=%b exp=0/0/0", q1, cnt1, done1); end
    op(SHR, 1'b1, 8'h00, 1'b0, 1'b1);
    checks++; if (q1 !== 1'b1 || cnt1 !== 1'b1 || done1 !== 1'b1) begin failures++; $display("FAIL w1_shr q=%b cnt=%b done=%b exp=1/1/1", q1, cnt1, done1); end
    op(SHL, 1'b1, 8'h00, 1'b0, 1'b1);
    checks++; if (q1 !== 1'b0 || cnt1 !== 1'b1 || done1 !== 1'b1) begin failures++; $display("FAIL w1_shl q=%b cnt=%b done=%b exp=0/1/1", q1, cnt1, done1); end
    D1 = 1'b1;
    op(LOAD, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++; if (q1 !== 1'b1 || cnt1 !== 1'b0 || sol1 !== 1'b1 || sor1 !== 1'b1) begin failures++; $display("FAIL w1_reload q=%b cnt=%b so=%b%b exp=1/0/11", q1, cnt1, sol1, sor1); end
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_piso();
    test_sipo_saturation();
    test_reset_mid();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
